// File: rtl/tlc5615_pkg.sv
// Shared definitions for the TLC5615 scheduler slice.
//   DA_W        : width of a DA code
//   FRAME_CLKS  : nominal length of one DA serial frame, in clocks
//   sched_state_t : scheduler FSM encoding
//   clamp_div() : applies the floor to a programmed sample divisor
package tlc5615_pkg;

    localparam int unsigned DA_W       = 10;
    localparam int unsigned FRAME_CLKS = 55;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_LO = 2'd2,
        S_WAIT_HI = 2'd3
    } sched_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] div, input logic [15:0] min_div);
        return (div < min_div) ? min_div : div;
    endfunction

endpackage

// File: rtl/zircon_tlc5615_rate_timer.sv
// Sample-rate timer for the stream requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable; low holds the timer at its reload point
//   cfg_div    : sample period in clocks, floored at MIN_DIV
//   tick       : one-cycle pulse every max(cfg_div, MIN_DIV) enabled clocks
module zircon_tlc5615_rate_timer
    import tlc5615_pkg::*;
#(
    parameter int unsigned MIN_DIV = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] cfg_div,
    output logic        tick
);

    logic [15:0] eff_div;
    logic [15:0] elapsed_q;

    assign eff_div = clamp_div(cfg_div, 16'(MIN_DIV));

    // Counts elapsed clocks rather than remaining ones so the reset value is a constant;
    // remaining = eff_div-1-elapsed_q, i.e. a down-count from eff_div-1 that ticks at zero.
    // The >= also covers cfg_div being lowered mid-period.
    assign tick = en && (elapsed_q >= (eff_div - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elapsed_q <= '0;
        end else if (!en || tick) begin
            elapsed_q <= '0;
        end else begin
            elapsed_q <= elapsed_q + 16'd1;
        end
    end

endmodule

// File: rtl/zircon_tlc5615_scheduler.sv
// Chooses which 10-bit code the TLC5615 DA logic sends and when.
// CPU one-shot writes take priority over a rate-paced sample stream; one frame in flight.
//   CLK_50M, RST_N        : clock, asynchronous active-low reset
//   cpu_wr/cpu_data       : CPU write strobe and code; cpu_busy = holding register full
//   strm_en/cfg_div       : stream enable and sample period (clocks)
//   strm_valid/strm_data  : stream sample; strm_ready pops it (same-cycle handshake)
//   DA_DATA/send_start    : code and start pulse to the DA logic; send_finish = DA idle
//   underrun/overrun/err_wd : sticky flags, cleared by clr (a same-cycle set wins)
//   sample_cnt            : stream samples sent, cleared by clr
module zircon_tlc5615_scheduler
    import tlc5615_pkg::*;
#(
    parameter int unsigned MIN_DIV  = 64,
    parameter int unsigned WD_LIMIT = 4
) (
    input  logic            CLK_50M,
    input  logic            RST_N,
    input  logic            cpu_wr,
    input  logic [DA_W-1:0] cpu_data,
    output logic            cpu_busy,
    input  logic            strm_en,
    input  logic [15:0]     cfg_div,
    input  logic            strm_valid,
    input  logic [DA_W-1:0] strm_data,
    output logic            strm_ready,
    output logic [DA_W-1:0] DA_DATA,
    output logic            send_start,
    input  logic            send_finish,
    output logic            underrun,
    output logic            overrun,
    output logic            err_wd,
    input  logic            clr,
    output logic [15:0]     sample_cnt
);

    localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

    sched_state_t    state_q;
    logic [DA_W-1:0] da_q;
    logic            send_start_q;
    logic [WD_W-1:0] wd_q;
    logic            err_wd_q;

    logic [DA_W-1:0] hold_q;
    logic            busy_q;
    logic            pending_q;
    logic            underrun_q;
    logic            overrun_q;
    logic [15:0]     sample_cnt_q;

    logic tick;
    logic idle_ready;
    logic take_cpu;
    logic take_strm;
    logic take_under;
    logic pend_clear;

    zircon_tlc5615_rate_timer #(
        .MIN_DIV (MIN_DIV)
    ) u_rate_timer (
        .clk     (CLK_50M),
        .rst_n   (RST_N),
        .en      (strm_en),
        .cfg_div (cfg_div),
        .tick    (tick)
    );

    // Arbitration happens only when idle and the DA logic reports idle.
    assign idle_ready = (state_q == S_IDLE) && send_finish;
    assign take_cpu   = idle_ready && busy_q;
    assign take_strm  = idle_ready && !busy_q && pending_q && strm_valid;
    assign take_under = idle_ready && !busy_q && pending_q && !strm_valid;
    assign pend_clear = take_strm || take_under;

    // Scheduler FSM with registered DA-side outputs.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            da_q         <= '0;
            send_start_q <= 1'b0;
            wd_q         <= '0;
            err_wd_q     <= 1'b0;
        end else begin
            send_start_q <= 1'b0;
            if (clr) begin
                err_wd_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (take_cpu) begin
                        da_q    <= hold_q;
                        state_q <= S_ISSUE;
                    end else if (take_strm) begin
                        da_q    <= strm_data;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    send_start_q <= 1'b1;
                    wd_q         <= '0;
                    state_q      <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!send_finish) begin
                        state_q <= S_WAIT_HI;
                    end else if (wd_q == WD_LAST) begin
                        err_wd_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_WAIT_HI: begin
                    if (send_finish) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // CPU holding register; a write while full is dropped, including in the issue cycle.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            hold_q <= '0;
            busy_q <= 1'b0;
        end else if (cpu_wr && !busy_q) begin
            hold_q <= cpu_data;
            busy_q <= 1'b1;
        end else if (take_cpu) begin
            busy_q <= 1'b0;
        end
    end

    // Pending tick. A tick in the cycle the pending one is consumed becomes the new pending;
    // a tick while one is still waiting is lost and flagged.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            pending_q <= 1'b0;
        end else if (!strm_en) begin
            pending_q <= 1'b0;
        end else if (tick) begin
            pending_q <= 1'b1;
        end else if (pend_clear) begin
            pending_q <= 1'b0;
        end
    end

    // Sticky flags and sample counter; the set/increment is applied after clr so it wins.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            if (clr) begin
                underrun_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            if (take_under) begin
                underrun_q <= 1'b1;
            end
            if (tick && pending_q && !pend_clear) begin
                overrun_q <= 1'b1;
            end
            if (take_strm) begin
                sample_cnt_q <= (clr ? 16'd0 : sample_cnt_q) + 16'd1;
            end else if (clr) begin
                sample_cnt_q <= '0;
            end
        end
    end

    assign cpu_busy   = busy_q;
    assign strm_ready = take_strm;
    assign DA_DATA    = da_q;
    assign send_start = send_start_q;
    assign err_wd     = err_wd_q;
    assign underrun   = underrun_q;
    assign overrun    = overrun_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_zircon_tlc5615_scheduler.sv
// Self-checking bench for zircon_tlc5615_scheduler: DA logic model plus a code scoreboard.
module tb_zircon_tlc5615_scheduler;
    import tlc5615_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [9:0]  cpu_data = '0;
    logic        cpu_busy;
    logic        strm_en = 1'b0;
    logic [15:0] cfg_div = '0;
    logic        strm_valid = 1'b0;
    logic [9:0]  strm_data = '0;
    logic        strm_ready;
    logic [9:0]  da_data;
    logic        send_start;
    logic        send_finish;
    logic        underrun;
    logic        overrun;
    logic        err_wd;
    logic        clr = 1'b0;
    logic [15:0] sample_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_starts = 0;

    logic [9:0] exp_q[$];
    logic [9:0] last_code = '0;
    bit         frame_open = 1'b0;
    logic       prev_finish = 1'b1;

    // DA logic model controls
    int busy_cnt = 0;
    int stall_extra = 0;
    bit stuck = 1'b0;

    zircon_tlc5615_scheduler dut (
        .CLK_50M     (clk),
        .RST_N       (rst_n),
        .cpu_wr      (cpu_wr),
        .cpu_data    (cpu_data),
        .cpu_busy    (cpu_busy),
        .strm_en     (strm_en),
        .cfg_div     (cfg_div),
        .strm_valid  (strm_valid),
        .strm_data   (strm_data),
        .strm_ready  (strm_ready),
        .DA_DATA     (da_data),
        .send_start  (send_start),
        .send_finish (send_finish),
        .underrun    (underrun),
        .overrun     (overrun),
        .err_wd      (err_wd),
        .clr         (clr),
        .sample_cnt  (sample_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // DA logic: finish drops 1 clk after start, rises 55 (+stall) clks later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_finish <= 1'b1;
            busy_cnt    <= 0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) send_finish <= 1'b1;
        end else if (send_start && !stuck) begin
            send_finish <= 1'b0;
            busy_cnt    <= FRAME_CLKS + stall_extra;
        end
    end

    // Stream source: every accepted sample becomes the next expected code.
    always @(negedge clk) begin
        if (rst_n && strm_valid && strm_ready) begin
            exp_q.push_back(strm_data);
            @(posedge clk);
            #1 strm_data = strm_data + 10'd1;
        end
    end

    // Scoreboard monitor: pop on send_start, confirm code is held until finish rises.
    always @(negedge clk) begin
        if (!rst_n) begin
            frame_open = 1'b0;
        end else begin
            if (send_start) begin
                n_starts++;
                check_eq("start_has_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    last_code = exp_q.pop_front();
                    check_eq("da_data_at_start", 32'(da_data), 32'(last_code));
                    frame_open = 1'b1;
                end
            end
            if (frame_open && send_finish && !prev_finish) begin
                check_eq("da_data_stable", 32'(da_data), 32'(last_code));
                frame_open = 1'b0;
            end
        end
        prev_finish = send_finish;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (send_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        step(2);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (send_finish && busy_cnt == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("da_model_idle", 32'(ok), 32'd1);
        step(4);
    endtask

    task automatic cpu_write(input logic [9:0] d);
        step(1);
        cpu_wr   = 1'b1;
        cpu_data = d;
        exp_q.push_back(d);
        step(1);
        cpu_wr = 1'b0;
    endtask

    task automatic pulse_clr();
        step(1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit ok;
        int t_prev;
        int n0;

        // Reset state
        step(3);
        @(negedge clk);
        check_eq("rst_da_data", 32'(da_data), 32'd0);
        check_eq("rst_send_start", 32'(send_start), 32'd0);
        check_eq("rst_cpu_busy", 32'(cpu_busy), 32'd0);
        check_eq("rst_flags", 32'({underrun, overrun, err_wd, strm_ready}), 32'd0);
        check_eq("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        rst_n = 1'b1;
        step(3);

        // T1: CPU write, start 3 clocks after the strobe
        step(1);
        cpu_wr   = 1'b1;
        cpu_data = 10'h2A5;
        exp_q.push_back(10'h2A5);
        @(negedge clk);
        check_eq("t1_busy_c0", 32'(cpu_busy), 32'd0);
        step(1);
        cpu_wr = 1'b0;
        @(negedge clk);
        check_eq("t1_busy_c1", 32'(cpu_busy), 32'd1);
        check_eq("t1_start_c1", 32'(send_start), 32'd0);
        @(negedge clk);
        check_eq("t1_busy_c2", 32'(cpu_busy), 32'd0);
        check_eq("t1_start_c2", 32'(send_start), 32'd0);
        @(negedge clk);
        check_eq("t1_start_c3", 32'(send_start), 32'd1);
        wait_idle(200);
        check_eq("t1_da_after_frame", 32'(da_data), 32'h2A5);

        // T2: stream at cfg_div=100, samples 0..7
        step(1);
        cfg_div    = 16'd100;
        strm_data  = 10'd0;
        strm_valid = 1'b1;
        strm_en    = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            wait_start(300, ok);
            check_eq("t2_start_seen", 32'(ok), 32'd1);
            if (i > 0) check_eq("t2_period", 32'(cyc - t_prev), 32'd100);
            t_prev = cyc;
        end
        strm_en    = 1'b0;
        strm_valid = 1'b0;
        wait_idle(200);
        check_eq("t2_sample_cnt", 32'(sample_cnt), 32'd8);
        check_eq("t2_flags", 32'({underrun, overrun, err_wd}), 32'd0);

        // T3: divisor clamp to 64, then overrun under a stalled DA
        step(1);
        cfg_div    = 16'd10;
        strm_valid = 1'b1;
        strm_en    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_start(300, ok);
            check_eq("t3_start_seen", 32'(ok), 32'd1);
            if (i > 0) check_eq("t3_period", 32'(cyc - t_prev), 32'd64);
            t_prev = cyc;
        end
        check_eq("t3_no_overrun", 32'(overrun), 32'd0);
        wait_start(300, ok);
        check_eq("t3_stall_start_seen", 32'(ok), 32'd1);
        stall_extra = 200;
        step(200);
        check_eq("t3_overrun", 32'(overrun), 32'd1);
        check_eq("t3_no_underrun", 32'(underrun), 32'd0);
        strm_en    = 1'b0;
        strm_valid = 1'b0;
        pulse_clr();
        @(negedge clk);
        check_eq("t3_overrun_clr", 32'(overrun), 32'd0);
        check_eq("t3_cnt_clr", 32'(sample_cnt), 32'd0);
        stall_extra = 0;
        wait_idle(400);

        // T4: tick and CPU write in the same cycle; CPU code must go first
        step(1);
        cfg_div    = 16'd100;
        strm_data  = 10'h155;
        strm_valid = 1'b1;
        strm_en    = 1'b1;
        repeat (99) @(posedge clk);
        #1;
        cpu_wr   = 1'b1;
        cpu_data = 10'h0CC;
        exp_q.push_back(10'h0CC);
        step(1);
        cpu_wr = 1'b0;
        n0 = n_starts;
        wait_start(300, ok);
        check_eq("t4_first_start", 32'(ok), 32'd1);
        check_eq("t4_first_code", 32'(da_data), 32'h0CC);
        step(1);
        wait_start(300, ok);
        check_eq("t4_second_start", 32'(ok), 32'd1);
        check_eq("t4_second_code", 32'(da_data), 32'h155);
        strm_en    = 1'b0;
        strm_valid = 1'b0;
        wait_idle(200);
        check_eq("t4_starts", 32'(n_starts - n0), 32'd2);

        // T5: underrun with no valid sample at the tick
        step(1);
        cfg_div = 16'd64;
        n0 = n_starts;
        strm_en = 1'b1;
        step(30);
        check_eq("t5_no_underrun_yet", 32'(underrun), 32'd0);
        step(50);
        check_eq("t5_underrun", 32'(underrun), 32'd1);
        check_eq("t5_no_start", 32'(n_starts - n0), 32'd0);
        check_eq("t5_da_holds", 32'(da_data), 32'h155);
        strm_en = 1'b0;
        pulse_clr();
        @(negedge clk);
        check_eq("t5_underrun_clr", 32'(underrun), 32'd0);

        // T6a: send_finish stuck high -> watchdog after WD_LIMIT clocks
        stuck = 1'b1;
        cpu_write(10'h3FF);
        wait_start(10, ok);
        check_eq("t6_start_seen", 32'(ok), 32'd1);
        check_eq("t6_wd_at_start", 32'(err_wd), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("t6_wd_before_limit", 32'(err_wd), 32'd0);
        @(negedge clk);
        check_eq("t6_wd_fired", 32'(err_wd), 32'd1);
        check_eq("t6_busy_clear", 32'(cpu_busy), 32'd0);
        pulse_clr();
        @(negedge clk);
        check_eq("t6_wd_clr", 32'(err_wd), 32'd0);
        stuck = 1'b0;
        step(3);

        // T6b: reset while waiting for send_finish to rise
        cpu_write(10'h1A5);
        wait_start(10, ok);
        check_eq("t6b_start_seen", 32'(ok), 32'd1);
        step(10);
        check_eq("t6b_mid_frame", 32'(send_finish), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6b_da_data", 32'(da_data), 32'd0);
        check_eq("t6b_outputs", 32'({send_start, cpu_busy, strm_ready, underrun, overrun, err_wd}),
                 32'd0);
        check_eq("t6b_sample_cnt", 32'(sample_cnt), 32'd0);
        check_eq("t6b_state", 32'(dut.state_q), 32'(S_IDLE));
        step(2);
        rst_n = 1'b1;
        step(5);
        check_eq("t6b_no_restart", 32'(send_start), 32'd0);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
